shift_unpacker: RTL and testbench
=================================

Name: shift_unpacker

Overview:
- Parallel-to-serial counterpart of the serial word collector.
- Accepts one wide vector of buffer_SIZE words of buffer_WIDTH bits each, then emits the words one per handshake on a narrow stream, lowest slice first.
- Sits between wide-result producers (PE array outputs, packed buffers) and 32-bit word-serial consumers (memory write port, output FIFO).
- Word order mirrors the collector: the first word collected, held in bits [buffer_WIDTH-1:0], is the first word emitted.

Parameters:
- buffer_SIZE, 8, number of words per wide vector; must be >= 2.
- buffer_WIDTH, 32, bits per word.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, reset: asynchronous assertion, active-low.
- data_i, input, buffer_WIDTH*buffer_SIZE, wide vector to unpack.
- valid_i, input, 1, data_i is valid.
- ready_o, output, 1, block can accept a new vector this cycle.
- data_o, output, buffer_WIDTH, current output word.
- valid_o, output, 1, data_o is valid.
- ready_i, input, 1, downstream accepts data_o this cycle.
- last_o, output, 1, present only with SHIFT_UNPACK_LAST_EN; marks the final word of a vector.

Behaviour:
- State: IDLE and BUSY (1 bit).
- Registers:
  - shift register sreg, buffer_WIDTH*buffer_SIZE bits.
  - word counter cnt, $clog2(buffer_SIZE) bits.
- Reset (rst_n low, asynchronous):
  - state=IDLE, sreg=0, cnt=0.
  - Outputs: valid_o=0, data_o=0, last_o=0.
  - ready_o reads 1 (IDLE), but no capture occurs while rst_n is low.
- Handshakes:
  - Input transfer is valid_i && ready_o.
  - Output transfer is valid_o && ready_i.
- ready_o (combinational): 1 in IDLE; 1 in BUSY only when cnt==buffer_SIZE-1 && ready_i. This combinational ready_i->ready_o path is intentional, for zero-bubble streaming.
- valid_o: 1 exactly when state==BUSY.
- data_o: always equals sreg[buffer_WIDTH-1:0].
- Input transfer: sreg<=data_i, cnt<=0, state<=BUSY. First word is visible on data_o with valid_o=1 on the next cycle (1-cycle latency).
- Output transfer, cnt<buffer_SIZE-1: sreg shifts right by buffer_WIDTH, zero-filling the top; cnt<=cnt+1.
- Output transfer, cnt==buffer_SIZE-1:
  - If an input transfer occurs in the same cycle, load the new vector, cnt<=0, stay BUSY. No bubble.
  - Otherwise state<=IDLE, cnt<=0, sreg unchanged.
- Stall (valid_o && !ready_i): sreg, cnt and data_o hold stable. valid_o never deasserts before the transfer completes.
- valid_i while BUSY and not on the final-word accept: ignored, ready_o=0. Upstream must hold data_i until the transfer.
- Throughput: exactly buffer_SIZE output beats per accepted vector; no word dropped or duplicated.
- Reset mid-vector: remaining words are discarded, block returns to IDLE, no partial output after reset release.
- Counter wrap: cnt never exceeds buffer_SIZE-1.

Optional Feature:
- Macro SHIFT_UNPACK_LAST_EN.
- Defined:
  - Adds output port last_o = valid_o && (cnt==buffer_SIZE-1), for packet framing by the downstream consumer.
  - Reset value of last_o is 0.
- Undefined:
  - Port last_o does not exist.
  - All other behaviour is identical.

Test Plan:
- Reset, then single vector: reset, then data_i = words 0x00000000..0x00000007 (word k = k) with valid_i=1 for one cycle, ready_i=1 always -> valid_o high for 8 consecutive cycles starting 1 cycle after accept; data_o = 0,1,..,7 in order; ready_o=0 during beats 0-6; IDLE afterwards.
- Backpressure: same vector, ready_i toggled 1,0,0,1,... -> data_o holds during stalls; exactly 8 transfers; sequence 0..7 intact.
- Back-to-back streaming: vector A = 0xA0..0xA7, then vector B = 0xB0..0xB7 presented with valid_i held high, ready_i=1 -> B is accepted in the cycle A's last word transfers; 16 consecutive valid beats A0..A7,B0..B7 with no bubble.
- Input while busy: valid_i pulsed with 0xDEAD.. during beat 3 of a vector -> ready_o=0, pulse ignored; output unaffected.
- Async reset mid-vector: assert rst_n=0 after beat 4 of a vector -> valid_o=0 and data_o=0 immediately, without a clock edge; after release, a new vector streams from its word 0.
- With SHIFT_UNPACK_LAST_EN defined: the first test -> last_o=1 only on the beat carrying word 7; 0 elsewhere and during reset.

Source files
------------

// File: rtl/shift_unpacker.sv
// Wide-to-narrow stream unpacker: loads buffer_SIZE words at once and emits them lowest slice first.
// Optional last_o framing output is enabled by defining SHIFT_UNPACK_LAST_EN.

module shift_unpacker #(
    parameter int unsigned buffer_SIZE  = 8,
    parameter int unsigned buffer_WIDTH = 32
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [buffer_WIDTH*buffer_SIZE-1:0] data_i,
    input  logic                                valid_i,
    output logic                                ready_o,
    output logic [buffer_WIDTH-1:0]             data_o,
    output logic                                valid_o,
    input  logic                                ready_i
`ifdef SHIFT_UNPACK_LAST_EN
    ,
    output logic                                last_o
`endif
);

    localparam int unsigned VecW = buffer_WIDTH * buffer_SIZE;
    localparam int unsigned CntW = (buffer_SIZE > 1) ? $clog2(buffer_SIZE) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(buffer_SIZE - 1);

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [VecW-1:0]   sreg_q, sreg_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic              in_xfer;
    logic              out_xfer;
    logic              on_last;

    assign on_last  = (cnt_q == CntLast);
    assign in_xfer  = valid_i && ready_o;
    assign out_xfer = valid_o && ready_i;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (in_xfer) begin
                    sreg_d  = data_i;
                    cnt_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (out_xfer) begin
                    if (!on_last) begin
                        sreg_d = sreg_q >> buffer_WIDTH;
                        cnt_d  = cnt_q + CntW'(1);
                    end else if (in_xfer) begin
                        // Final word leaves while the next vector arrives: no bubble.
                        sreg_d = data_i;
                        cnt_d  = '0;
                    end else begin
                        cnt_d   = '0;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs; ready_o depends combinationally on ready_i for zero-bubble streaming.
    always_comb begin
        valid_o = (state_q == StBusy);
        ready_o = (state_q == StIdle) || (on_last && ready_i);
        data_o  = sreg_q[buffer_WIDTH-1:0];
    end

`ifdef SHIFT_UNPACK_LAST_EN
    always_comb begin
        last_o = (state_q == StBusy) && on_last;
    end
`endif

endmodule

// File: tb/tb_shift_unpacker.sv
// Directed bench for shift_unpacker with a queue-based model checked on every falling edge.
// Define SHIFT_UNPACK_LAST_EN to also check last_o.

module tb_shift_unpacker;

    localparam int unsigned SIZE  = 8;
    localparam int unsigned WIDTH = 32;

    logic                    clk;
    logic                    rst_n;
    logic [WIDTH*SIZE-1:0]   data_i;
    logic                    valid_i;
    logic                    ready_o;
    logic [WIDTH-1:0]        data_o;
    logic                    valid_o;
    logic                    ready_i;
`ifdef SHIFT_UNPACK_LAST_EN
    logic                    last_o;
`endif

    int n_cmp = 0;
    int n_err = 0;

    shift_unpacker #(
        .buffer_SIZE  (SIZE),
        .buffer_WIDTH (WIDTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .valid_o (valid_o),
        .ready_i (ready_i)
`ifdef SHIFT_UNPACK_LAST_EN
        ,
        .last_o  (last_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the words still owed downstream, plus what data_o shows when idle.
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] idle_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            idle_data = '0;
        end else begin
            bit m_valid;
            bit m_ready;
            m_valid = (exp_q.size() > 0);
            m_ready = !m_valid || (exp_q.size() == 1 && ready_i);
            if (m_valid && ready_i) begin
                idle_data = exp_q[0];
                void'(exp_q.pop_front());
            end
            if (valid_i && m_ready) begin
                for (int k = 0; k < SIZE; k++) exp_q.push_back(data_i[k*WIDTH +: WIDTH]);
            end
        end
    end

    always @(negedge clk) begin
        bit m_valid;
        m_valid = (exp_q.size() > 0);
        check("model_valid", 64'(valid_o), 64'(m_valid));
        check("model_data", 64'(data_o), 64'(m_valid ? exp_q[0] : idle_data));
        check("model_ready", 64'(ready_o),
              64'(!m_valid || (exp_q.size() == 1 && ready_i)));
`ifdef SHIFT_UNPACK_LAST_EN
        check("model_last", 64'(last_o), 64'(m_valid && exp_q.size() == 1));
`endif
    end

    task automatic load_vec(input logic [WIDTH-1:0] base);
        for (int k = 0; k < SIZE; k++) data_i[k*WIDTH +: WIDTH] = base + WIDTH'(k);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a vector for one accepting cycle from IDLE; returns after the accept edge.
    task automatic send_one(input logic [WIDTH-1:0] base);
        load_vec(base);
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
    endtask

    // Checks beats of a vector with ready_i=1, starting on the cycle after accept.
    task automatic expect_stream(input string name, input logic [WIDTH-1:0] base);
        for (int k = 0; k < SIZE; k++) begin
            check({name, "_valid"}, 64'(valid_o), 64'd1);
            check({name, "_data"}, 64'(data_o), 64'(base + WIDTH'(k)));
            check({name, "_ready"}, 64'(ready_o), 64'(k == SIZE - 1));
`ifdef SHIFT_UNPACK_LAST_EN
            check({name, "_last"}, 64'(last_o), 64'(k == SIZE - 1));
`endif
            step();
        end
        check({name, "_idle"}, 64'(valid_o), 64'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] got[$];
        int               guard;
        bit               drop;

        rst_n   = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        data_i  = '0;
        #1;
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_data", 64'(data_o), 64'd0);
        check("rst_ready", 64'(ready_o), 64'd1);
`ifdef SHIFT_UNPACK_LAST_EN
        check("rst_last", 64'(last_o), 64'd0);
`endif
        // valid_i during reset must not be captured
        load_vec(32'h55);
        valid_i = 1'b1;
        repeat (3) step();
        valid_i = 1'b0;
        check("rst_nocap", 64'(valid_o), 64'd0);
        rst_n = 1'b1;
        step();

        // Single vector, words 0..7
        send_one(32'h0);
        expect_stream("single", 32'h0);
        check("single_hold", 64'(data_o), 64'h7);

        // Backpressure with ready_i pattern 1,0,0,1,...
        send_one(32'h0);
        got.delete();
        guard = 0;
        while (got.size() < SIZE && guard < 100) begin
            ready_i = ((guard % 3) == 0);
            #1;
            if (valid_o && ready_i) got.push_back(data_o);
            step();
            guard++;
        end
        ready_i = 1'b1;
        check("bp_count", 64'(got.size()), 64'(SIZE));
        for (int k = 0; k < got.size(); k++) check("bp_seq", 64'(got[k]), 64'(k));
        #1;
        check("bp_idle", 64'(valid_o), 64'd0);

        // Back-to-back: B held valid until it is accepted on A's final beat
        send_one(32'hA0);
        load_vec(32'hB0);
        valid_i = 1'b1;
        for (int i = 0; i < 2 * SIZE; i++) begin
            check("b2b_valid", 64'(valid_o), 64'd1);
            check("b2b_data", 64'(data_o),
                  (i < SIZE) ? 64'(32'hA0 + i) : 64'(32'hB0 + i - SIZE));
            drop = valid_i && ready_o;
            if (i == SIZE - 1) check("b2b_accept", 64'(ready_o), 64'd1);
            step();
            if (drop) valid_i = 1'b0;
        end
        check("b2b_idle", 64'(valid_o), 64'd0);

        // valid_i pulse while busy must be ignored
        send_one(32'h20);
        for (int k = 0; k < SIZE; k++) begin
            if (k == 3) begin
                data_i  = {SIZE{32'hDEADBEEF}};
                valid_i = 1'b1;
                #1;
                check("busy_ready", 64'(ready_o), 64'd0);
            end
            check("busy_data", 64'(data_o), 64'(32'h20 + k));
            step();
            valid_i = 1'b0;
        end
        check("busy_idle", 64'(valid_o), 64'd0);

        // Asynchronous reset mid-vector
        send_one(32'h30);
        repeat (5) step();
        check("mid_data", 64'(data_o), 64'h35);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(valid_o), 64'd0);
        check("arst_data", 64'(data_o), 64'd0);
        check("arst_ready", 64'(ready_o), 64'd1);
`ifdef SHIFT_UNPACK_LAST_EN
        check("arst_last", 64'(last_o), 64'd0);
`endif
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_idle", 64'(valid_o), 64'd0);
        send_one(32'h40);
        expect_stream("post_rst", 32'h40);

        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
